// File: rtl/tdm_slot_scheduler_pkg.sv
// Shared types and helpers for the TDM slot scheduler (package tdm_pkg).
// The round-robin channel search lives here so the top stays readable.
package tdm_pkg;

    localparam int unsigned N_CH = 4;
    localparam int unsigned CH_W = 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} tdm_state_t;

    // Next set bit of mask strictly after cur, wrapping 3 -> 0; returns cur if mask is empty.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] cur,
                                                input logic [N_CH-1:0] mask);
        logic [CH_W-1:0] res;
        logic [CH_W-1:0] cand;
        logic            found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= int'(N_CH); i++) begin
            cand = cur + CH_W'(i);
            if (!found && mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // True when cur is the last active channel before the round-robin wraps.
    function automatic logic is_frame_end(input logic [CH_W-1:0] cur,
                                          input logic [N_CH-1:0] mask);
        return next_ch(cur, mask) <= cur;
    endfunction

endpackage

// File: rtl/tdm_slot_scheduler_if.sv
// Control/status bundle between a TDM scheduler and its controller.
// The scheduler takes the slave side; the controller (or bench) drives the master side.
interface tdm_slot_scheduler_if #(
    parameter int unsigned DWELL_W = 4
);
    import tdm_pkg::*;

    logic                start;
    logic                stop;
    logic [N_CH-1:0]     req;
    logic [DWELL_W-1:0]  dwell;
    logic [CH_W-1:0]     s;
    logic                e;
    logic [CH_W-1:0]     t;
    logic                ed;
    logic                busy;
    logic                slot_strobe;
    logic                frame_done;

    modport master (
        output start, stop, req, dwell,
        input  s, e, t, ed, busy, slot_strobe, frame_done
    );

    modport slave (
        input  start, stop, req, dwell,
        output s, e, t, ed, busy, slot_strobe, frame_done
    );

endinterface

// File: rtl/tdm_slot_scheduler_sel_delay_line.sv
// LAT-deep shift register carrying the mux-side {e, s} to the demux-side {ed, t}.
module sel_delay_line
    import tdm_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH_W-1:0] i_s,
    input  logic            i_e,
    output logic [CH_W-1:0] o_t,
    output logic            o_ed
);

    logic [CH_W:0] r_pipe [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LAT); i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= {i_e, i_s};
            for (int i = 1; i < int'(LAT); i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_t  = r_pipe[LAT-1][CH_W-1:0];
    assign o_ed = r_pipe[LAT-1][CH_W];

endmodule

// File: rtl/tdm_slot_scheduler.sv
// TDM slot sequencer driving a 4:1 mux / 1:4 demux pair.
// Define SCHED_SKIP_EN to skip idle channels; otherwise all four channels get fixed slots.
module tdm_slot_scheduler
    import tdm_pkg::*;
#(
    parameter int unsigned DWELL_W = 4,
    parameter int unsigned LAT     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    tdm_slot_scheduler_if.slave bus
);

    tdm_state_t         r_state;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_dwell;
    logic [N_CH-1:0]    r_req_q;
    logic               r_stop_q;
    logic [CH_W-1:0]    r_s;
    logic               r_e;
    logic               r_busy;
    logic               r_slot_strobe;
    logic               r_frame_done;

    logic [DWELL_W-1:0] w_dwell_eff;
    logic               w_last;
    logic               w_stop_any;
    logic               w_go;
    logic [CH_W-1:0]    w_first_ch;
    logic               w_first_en;
    logic               w_first_fd;
    logic [CH_W-1:0]    w_nxt_ch;
    logic               w_nxt_en;
    logic               w_nxt_fd;
    logic               w_cur_fd;
    logic               w_hold_en;
    logic               w_req_empty;
    logic [CH_W-1:0]    w_t;
    logic               w_ed;

    assign w_dwell_eff = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
    assign w_last      = (r_cnt == r_dwell - DWELL_W'(1));
    assign w_stop_any  = r_stop_q | bus.stop;

`ifdef SCHED_SKIP_EN
    assign w_go        = bus.start & ~bus.stop & (|bus.req);
    assign w_first_ch  = next_ch(CH_W'(N_CH - 1), bus.req);
    assign w_first_en  = 1'b1;
    assign w_first_fd  = is_frame_end(w_first_ch, bus.req);
    assign w_nxt_ch    = next_ch(r_s, bus.req);
    assign w_nxt_en    = 1'b1;
    assign w_nxt_fd    = is_frame_end(w_nxt_ch, bus.req);
    assign w_cur_fd    = is_frame_end(r_s, r_req_q);
    assign w_hold_en   = 1'b1;
    assign w_req_empty = (bus.req == '0);
`else
    assign w_go        = bus.start & ~bus.stop;
    assign w_first_ch  = '0;
    assign w_first_en  = bus.req[0];
    assign w_first_fd  = 1'b0;
    assign w_nxt_ch    = r_s + CH_W'(1);
    assign w_nxt_en    = bus.req[w_nxt_ch];
    assign w_nxt_fd    = (w_nxt_ch == CH_W'(N_CH - 1));
    assign w_cur_fd    = (r_s == CH_W'(N_CH - 1));
    assign w_hold_en   = r_req_q[r_s];
    assign w_req_empty = 1'b0;
`endif

    // frame_done is registered, so it is decided one edge ahead: when the next cycle is a slot's last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_dwell       <= DWELL_W'(1);
            r_req_q       <= '0;
            r_stop_q      <= 1'b0;
            r_s           <= '0;
            r_e           <= 1'b0;
            r_busy        <= 1'b0;
            r_slot_strobe <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_slot_strobe <= 1'b0;
            r_frame_done  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_s      <= '0;
                    r_e      <= 1'b0;
                    r_busy   <= 1'b0;
                    r_stop_q <= 1'b0;
                    r_cnt    <= '0;
                    if (w_go) begin
                        r_state       <= RUN;
                        r_busy        <= 1'b1;
                        r_dwell       <= w_dwell_eff;
                        r_req_q       <= bus.req;
                        r_s           <= w_first_ch;
                        r_e           <= w_first_en;
                        r_slot_strobe <= 1'b1;
                        r_frame_done  <= (w_dwell_eff == DWELL_W'(1)) && w_first_fd;
                    end
                end
                RUN: begin
                    if (bus.stop) r_stop_q <= 1'b1;
                    if (w_last) begin
                        r_cnt <= '0;
                        if (w_stop_any || w_req_empty) begin
                            r_state <= DRAIN;
                            r_e     <= 1'b0;
                        end else begin
                            r_req_q       <= bus.req;
                            r_s           <= w_nxt_ch;
                            r_e           <= w_nxt_en;
                            r_slot_strobe <= 1'b1;
                            r_frame_done  <= (r_dwell == DWELL_W'(1)) && w_nxt_fd;
                        end
                    end else begin
                        r_cnt        <= r_cnt + DWELL_W'(1);
                        r_e          <= w_hold_en;
                        r_frame_done <= (r_cnt + DWELL_W'(1) == r_dwell - DWELL_W'(1)) && w_cur_fd;
                    end
                end
                DRAIN: begin
                    if (r_cnt == DWELL_W'(LAT - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_s     <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + DWELL_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sel_delay_line #(
        .LAT (LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .i_s   (r_s),
        .i_e   (r_e),
        .o_t   (w_t),
        .o_ed  (w_ed)
    );

    assign bus.s           = r_s;
    assign bus.e           = r_e;
    assign bus.t           = w_t;
    assign bus.ed          = w_ed;
    assign bus.busy        = r_busy;
    assign bus.slot_strobe = r_slot_strobe;
    assign bus.frame_done  = r_frame_done;

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Directed bench for tdm_slot_scheduler: a per-cycle vector table plus hand-written
// sequences for reset, mid-slot req changes and illegal starts. Honours SCHED_SKIP_EN.
module tb_tdm_slot_scheduler;
    import tdm_pkg::*;

    localparam int unsigned DWELL_W = 4;
    localparam int unsigned LAT     = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    tdm_slot_scheduler_if #(.DWELL_W(DWELL_W)) bus ();

    tdm_slot_scheduler #(
        .DWELL_W (DWELL_W),
        .LAT     (LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tag;
        logic       start;
        logic       stop;
        logic [3:0] req;
        logic [3:0] dwell;
        logic [1:0] s;
        logic       e;
        logic       busy;
        logic       ss;
        logic       fd;
    } vec_t;

    vec_t       tbl[$];
    logic [2:0] hist[LAT+1];

    function automatic void add(input logic [7:0] tag, input logic st, input logic sp,
                                input logic [3:0] rq, input logic [3:0] dw, input logic [1:0] s,
                                input logic e, input logic b, input logic ss, input logic fd);
        vec_t v;
        v.tag = tag; v.start = st; v.stop = sp; v.req = rq; v.dwell = dw;
        v.s = s; v.e = e; v.busy = b; v.ss = ss; v.fd = fd;
        tbl.push_back(v);
    endfunction

    function automatic void check(input string name, input logic [15:0] act,
                                  input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] outs();
        return {7'b0, bus.s, bus.t, bus.e, bus.ed, bus.busy, bus.slot_strobe, bus.frame_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (bus.busy === 1'b1 && n < bound) begin
            step();
            n++;
        end
        check(name, {15'b0, bus.busy}, 16'h0);
    endtask

    task automatic settle_idle();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        repeat (LAT + 1) step();
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.req   = '0;
        bus.dwell = '0;
        repeat (3) step();
        check("in_reset", outs(), 16'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("idle_after_reset[%0d]", i), outs(), 16'h0);
        end

        // Start blocked by a simultaneous stop, then start with an empty mask.
        bus.start = 1'b1; bus.stop = 1'b1; bus.req = 4'hf; bus.dwell = 4'd3;
        step();
        check("start_with_stop", {15'b0, bus.busy}, 16'h0);
        bus.stop = 1'b0; bus.req = 4'h0;
        step();
`ifdef SCHED_SKIP_EN
        check("start_req0_skip", {13'b0, bus.s, bus.busy}, 16'h0);
`else
        check("start_req0_fixed", {12'b0, bus.s, bus.e, bus.busy}, {12'b0, 2'd0, 1'b0, 1'b1});
        bus.start = 1'b0; bus.stop = 1'b1;
        wait_idle("req0_stop_idle", 20);
`endif
        settle_idle();

        // Seq A: all channels, dwell 3, stop in the first cycle of the second frame's slot 0.
        add("A", 1, 0, 4'hf, 3, 0, 1, 1, 1, 0);
        add("A", 0, 0, 4'hf, 3, 0, 1, 1, 0, 0);
        add("A", 0, 0, 4'hf, 3, 0, 1, 1, 0, 0);
        for (int c = 1; c < 4; c++) begin
            add("A", 0, 0, 4'hf, 3, 2'(c), 1, 1, 1, 0);
            add("A", 0, 0, 4'hf, 3, 2'(c), 1, 1, 0, 0);
            add("A", 0, 0, 4'hf, 3, 2'(c), 1, 1, 0, (c == 3));
        end
        add("A", 0, 0, 4'hf, 3, 0, 1, 1, 1, 0);
        add("A", 0, 1, 4'hf, 3, 0, 1, 1, 0, 0);
        add("A", 0, 0, 4'hf, 3, 0, 1, 1, 0, 0);
        add("A", 0, 0, 4'hf, 3, 0, 0, 1, 0, 0);
        add("A", 0, 0, 4'hf, 3, 0, 0, 1, 0, 0);
        add("A", 0, 0, 4'hf, 3, 0, 0, 0, 0, 0);
        add("A", 0, 0, 4'hf, 3, 0, 0, 0, 0, 0);
        // Seq B: sparse mask 1010, dwell 2, stop mid-slot on channel 3.
`ifdef SCHED_SKIP_EN
        add("B", 1, 0, 4'ha, 2, 1, 1, 1, 1, 0);
        add("B", 0, 0, 4'ha, 2, 1, 1, 1, 0, 0);
        add("B", 0, 0, 4'ha, 2, 3, 1, 1, 1, 0);
        add("B", 0, 0, 4'ha, 2, 3, 1, 1, 0, 1);
        add("B", 0, 0, 4'ha, 2, 1, 1, 1, 1, 0);
        add("B", 0, 0, 4'ha, 2, 1, 1, 1, 0, 0);
        add("B", 0, 0, 4'ha, 2, 3, 1, 1, 1, 0);
        add("B", 0, 1, 4'ha, 2, 3, 1, 1, 0, 1);
`else
        add("B", 1, 0, 4'ha, 2, 0, 0, 1, 1, 0);
        add("B", 0, 0, 4'ha, 2, 0, 0, 1, 0, 0);
        add("B", 0, 0, 4'ha, 2, 1, 1, 1, 1, 0);
        add("B", 0, 0, 4'ha, 2, 1, 1, 1, 0, 0);
        add("B", 0, 0, 4'ha, 2, 2, 0, 1, 1, 0);
        add("B", 0, 0, 4'ha, 2, 2, 0, 1, 0, 0);
        add("B", 0, 0, 4'ha, 2, 3, 1, 1, 1, 0);
        add("B", 0, 1, 4'ha, 2, 3, 1, 1, 0, 1);
`endif
        add("B", 0, 0, 4'ha, 2, 3, 0, 1, 0, 0);
        add("B", 0, 0, 4'ha, 2, 3, 0, 1, 0, 0);
        add("B", 0, 0, 4'ha, 2, 0, 0, 0, 0, 0);
        add("B", 0, 0, 4'ha, 2, 0, 0, 0, 0, 0);

        for (int k = 0; k <= int'(LAT); k++) hist[k] = '0;
        for (int i = 0; i < tbl.size(); i++) begin
            bus.start = tbl[i].start;
            bus.stop  = tbl[i].stop;
            bus.req   = tbl[i].req;
            bus.dwell = tbl[i].dwell;
            step();
            for (int k = int'(LAT); k > 0; k--) hist[k] = hist[k-1];
            hist[0] = {tbl[i].e, tbl[i].s};
            check($sformatf("vec_%c[%0d] s/e/busy/strobe/frame", tbl[i].tag, i),
                  {10'b0, bus.s, bus.e, bus.busy, bus.slot_strobe, bus.frame_done},
                  {10'b0, tbl[i].s, tbl[i].e, tbl[i].busy, tbl[i].ss, tbl[i].fd});
            check($sformatf("vec_%c[%0d] t/ed", tbl[i].tag, i),
                  {13'b0, bus.ed, bus.t}, {13'b0, hist[LAT]});
        end
        settle_idle();

        // req change mid-slot only takes effect at the boundary.
        bus.req = 4'b0001; bus.dwell = 4'd3; bus.start = 1'b1;
        step();
        check("req_chg_first", {13'b0, bus.s, bus.e}, {13'b0, 2'd0, 1'b1});
        bus.start = 1'b0; bus.req = 4'b0100;
        step();
        check("req_chg_hold1", {14'b0, bus.s}, 16'h0);
        step();
        check("req_chg_hold2", {14'b0, bus.s}, 16'h0);
        step();
`ifdef SCHED_SKIP_EN
        check("req_chg_boundary", {12'b0, bus.s, bus.e, bus.slot_strobe}, {12'b0, 2'd2, 1'b1, 1'b1});
        bus.req = 4'b0000;
        step();
        step();
        step();
        check("req0_drain", {12'b0, bus.s, bus.e, bus.busy}, {12'b0, 2'd2, 1'b0, 1'b1});
        step();
        check("req0_drain_last", {15'b0, bus.busy}, 16'h1);
        step();
        check("req0_idle", {13'b0, bus.s, bus.busy}, 16'h0);
`else
        check("req_chg_boundary", {12'b0, bus.s, bus.e, bus.slot_strobe}, {12'b0, 2'd1, 1'b0, 1'b1});
        bus.stop = 1'b1;
        wait_idle("req_chg_stop_idle", 20);
`endif
        settle_idle();

        // Asynchronous reset mid-slot, then restart with dwell 0 (1-cycle slots).
        bus.req = 4'hf; bus.dwell = 4'd5; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1 check("async_reset_mid_slot", outs(), 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.dwell = 4'd0; bus.start = 1'b1;
        step();
        check("dwell0_slot0", {11'b0, bus.s, bus.busy, bus.slot_strobe, bus.frame_done},
              {11'b0, 2'd0, 1'b1, 1'b1, 1'b0});
        bus.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("dwell0_slot%0d", c),
                  {11'b0, bus.s, bus.busy, bus.slot_strobe, bus.frame_done},
                  {11'b0, 2'(c), 1'b1, 1'b1, (c == 3)});
        end
        bus.stop = 1'b1;
        wait_idle("dwell0_stop_idle", 20);
        bus.stop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
